// File: rtl/rvh_l1d_cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvh_l1d_cc_pkg
// Description : L1D cache-coherence types shared by the snoop controller,
//               its decoder and the SCU/pipeline-facing interface.
// Revision    : 1.0 - initial release
// ============================================================================
package rvh_l1d_cc_pkg;

  localparam int unsigned PADDR_WIDTH         = 40;
  localparam int unsigned L1D_OFFSET_WIDTH    = 6;
  localparam int unsigned L1D_LINE_WIDTH      = 512;
  localparam int unsigned SCU_ID_WIDTH        = 4;
  localparam int unsigned L1D_LINE_ADDR_WIDTH = PADDR_WIDTH - L1D_OFFSET_WIDTH;

  // Snoop opcodes issued by the SCU
  typedef enum logic [2:0] {
    SNP_SHARED        = 3'd0,
    SNP_ONCE          = 3'd1,
    SNP_UNIQUE        = 3'd2,
    SNP_CLEAN_INVALID = 3'd3,
    SNP_MAKE_INVALID  = 3'd4
  } snp_opcode_e;

  // Raw snoop request from the SCU (line granular)
  typedef struct packed {
    logic [SCU_ID_WIDTH-1:0]        id;
    snp_opcode_e                    opcode;
    logic [L1D_LINE_ADDR_WIDTH-1:0] line_addr;
  } cache_scu_cc_snp_t;

  // Decoded snoop as held in the request buffer and sent to the pipeline
  typedef struct packed {
    logic [SCU_ID_WIDTH-1:0]        id;
    logic [L1D_LINE_ADDR_WIDTH-1:0] line_addr;
    logic                           snp_leave_invalid;
    logic                           snp_return_clean_data;
    logic                           snp_return_dirty_data;
  } snp_req_buf_t;

  // Snoop response returned to the SCU
  typedef struct packed {
    logic [SCU_ID_WIDTH-1:0]   id;
    logic                      pass_dirty;
    logic                      data_vld;
    logic                      is_shared;
    logic [L1D_LINE_WIDTH-1:0] data;
  } cache_scu_cc_snp_resp_t;

  // Head-of-buffer sequencing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } snp_ctrl_state_e;

endpackage : rvh_l1d_cc_pkg
`default_nettype wire

// File: rtl/rvh_l1d_snp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rvh_l1d_snp_ctrl_if
// Description : Bundle of the SCU snoop, MSHR check, pipeline lookup and
//               snoop response channels seen by the snoop controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface rvh_l1d_snp_ctrl_if;
  import rvh_l1d_cc_pkg::*;

  logic                                snp_req_vld_i;
  cache_scu_cc_snp_t                   snp_req_i;
  logic                                snp_req_rdy_o;
  logic [L1D_LINE_ADDR_WIDTH-1:0]      snp_chk_line_addr_o;
  logic                                snp_chk_conflict_i;
  logic                                snp_pipe_req_vld_o;
  snp_req_buf_t                        snp_pipe_req_o;
  logic                                snp_pipe_req_rdy_i;
  logic                                snp_pipe_resp_vld_i;
  logic                                snp_pipe_resp_hit_i;
  logic                                snp_pipe_resp_dirty_i;
  logic [L1D_LINE_WIDTH-1:0]           snp_pipe_resp_data_i;
  logic                                snp_resp_vld_o;
  cache_scu_cc_snp_resp_t              snp_resp_o;
  logic                                snp_resp_rdy_i;
  logic                                snp_busy_o;

  // Snoop controller side
  modport slave (
    input  snp_req_vld_i, snp_req_i, snp_chk_conflict_i, snp_pipe_req_rdy_i,
           snp_pipe_resp_vld_i, snp_pipe_resp_hit_i, snp_pipe_resp_dirty_i,
           snp_pipe_resp_data_i, snp_resp_rdy_i,
    output snp_req_rdy_o, snp_chk_line_addr_o, snp_pipe_req_vld_o, snp_pipe_req_o,
           snp_resp_vld_o, snp_resp_o, snp_busy_o
  );

  // Environment side (SCU, MSHR checker, pipeline)
  modport master (
    output snp_req_vld_i, snp_req_i, snp_chk_conflict_i, snp_pipe_req_rdy_i,
           snp_pipe_resp_vld_i, snp_pipe_resp_hit_i, snp_pipe_resp_dirty_i,
           snp_pipe_resp_data_i, snp_resp_rdy_i,
    input  snp_req_rdy_o, snp_chk_line_addr_o, snp_pipe_req_vld_o, snp_pipe_req_o,
           snp_resp_vld_o, snp_resp_o, snp_busy_o
  );

endinterface : rvh_l1d_snp_ctrl_if
`default_nettype wire

// File: rtl/rvh_l1d_snp_dec.sv
`default_nettype none
// ============================================================================
// Module      : rvh_l1d_snp_dec
// Description : Decodes an SCU snoop opcode into the final line state and
//               data-return policy carried by the buffered request.
// Revision    : 1.0 - initial release
// ============================================================================
module rvh_l1d_snp_dec
  import rvh_l1d_cc_pkg::*;
(
  input  cache_scu_cc_snp_t snp_req_i,
  output snp_req_buf_t      snp_req_buf_o
);

  // Opcode to policy table; unknown opcodes keep the line and return nothing
  always_comb begin
    snp_req_buf_o           = '0;
    snp_req_buf_o.id        = snp_req_i.id;
    snp_req_buf_o.line_addr = snp_req_i.line_addr;
    case (snp_req_i.opcode)
      SNP_SHARED: begin
        snp_req_buf_o.snp_return_dirty_data = 1'b1;
      end
      SNP_ONCE: begin
        snp_req_buf_o.snp_return_clean_data = 1'b1;
        snp_req_buf_o.snp_return_dirty_data = 1'b1;
      end
      SNP_UNIQUE, SNP_CLEAN_INVALID: begin
        snp_req_buf_o.snp_leave_invalid     = 1'b1;
        snp_req_buf_o.snp_return_dirty_data = 1'b1;
      end
      SNP_MAKE_INVALID: begin
        snp_req_buf_o.snp_leave_invalid     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : rvh_l1d_snp_dec
`default_nettype wire

// File: rtl/rvh_l1d_snp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rvh_l1d_snp_ctrl
// Description : L1D snoop controller. Buffers SCU snoops in order and walks
//               the head through MSHR conflict check, pipeline lookup and
//               the snoop response back to the SCU.
// Revision    : 1.0 - initial release
// ============================================================================
module rvh_l1d_snp_ctrl
  import rvh_l1d_cc_pkg::*;
#(
  parameter int unsigned SNP_BUF_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  rvh_l1d_snp_ctrl_if.slave        bus
);

  localparam int unsigned PTR_W = (SNP_BUF_DEPTH > 1) ? $clog2(SNP_BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SNP_BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(SNP_BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(SNP_BUF_DEPTH);

  snp_req_buf_t           r_buf [SNP_BUF_DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_nxt;
  snp_ctrl_state_e        r_state;
  logic                   r_pipe_req_vld;
  logic                   r_resp_vld;
  cache_scu_cc_snp_resp_t r_resp;

  snp_req_buf_t           w_dec;
  snp_req_buf_t           w_head;
  logic                   w_full;
  logic                   w_enq;
  logic                   w_pop;
  logic                   w_data_vld;

  rvh_l1d_snp_dec u_snp_dec (
    .snp_req_i     (bus.snp_req_i),
    .snp_req_buf_o (w_dec)
  );

  assign w_head     = r_buf[r_head];
  assign w_full     = (r_count == c_cnt_full);
  // No bypass: a full buffer refuses even when the head pops this cycle
  assign w_enq      = bus.snp_req_vld_i && !w_full;
  assign w_pop      = (r_state == RESP) && bus.snp_resp_rdy_i;
  assign w_data_vld = bus.snp_pipe_resp_hit_i &&
                      ((bus.snp_pipe_resp_dirty_i && w_head.snp_return_dirty_data) ||
                       w_head.snp_return_clean_data);

  // Occupancy after this cycle's enqueue/pop
  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_enq && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // In-order snoop buffer: decoded entries in at the tail, popped at the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SNP_BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_buf[r_tail] <= w_dec;
        r_tail        <= (r_tail == c_ptr_last) ? '0 : r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == c_ptr_last) ? '0 : r_head + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Head sequencer with registered valids and response payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_pipe_req_vld <= 1'b0;
      r_resp_vld     <= 1'b0;
      r_resp         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_enq || (r_count != '0)) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (!bus.snp_chk_conflict_i) begin
            r_state        <= ISSUE;
            r_pipe_req_vld <= 1'b1;
          end
        end
        ISSUE: begin
          if (bus.snp_pipe_req_rdy_i) begin
            r_state        <= WAIT;
            r_pipe_req_vld <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.snp_pipe_resp_vld_i) begin
            r_state           <= RESP;
            r_resp_vld        <= 1'b1;
            r_resp.id         <= w_head.id;
            r_resp.pass_dirty <= bus.snp_pipe_resp_hit_i && bus.snp_pipe_resp_dirty_i &&
                                 w_head.snp_return_dirty_data;
            r_resp.data_vld   <= w_data_vld;
            r_resp.is_shared  <= bus.snp_pipe_resp_hit_i && !w_head.snp_leave_invalid;
            r_resp.data       <= w_data_vld ? bus.snp_pipe_resp_data_i : '0;
          end
        end
        RESP: begin
          if (bus.snp_resp_rdy_i) begin
            r_resp_vld <= 1'b0;
            r_state    <= (w_count_nxt != '0) ? CHECK : IDLE;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_pipe_req_vld <= 1'b0;
          r_resp_vld     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.snp_req_rdy_o       = !w_full;
  assign bus.snp_chk_line_addr_o = (r_count == '0) ? '0 : w_head.line_addr;
  assign bus.snp_pipe_req_vld_o  = r_pipe_req_vld;
  assign bus.snp_pipe_req_o      = w_head;
  assign bus.snp_resp_vld_o      = r_resp_vld;
  assign bus.snp_resp_o          = r_resp;
  assign bus.snp_busy_o          = (r_count != '0);

  // Only one lookup may be outstanding; a response outside WAIT is dropped
  a_pipe_resp_in_wait: assert property (
    @(posedge clk) disable iff (rst) bus.snp_pipe_resp_vld_i |-> (r_state == WAIT)
  ) else $warning("snoop pipeline response outside WAIT was ignored");

endmodule : rvh_l1d_snp_ctrl
`default_nettype wire

// File: tb/tb_rvh_l1d_snp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvh_l1d_snp_ctrl
// Description : Scoreboard bench for the L1D snoop controller with a small
//               pipeline responder and a response monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvh_l1d_snp_ctrl;
  import rvh_l1d_cc_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 640;

  typedef struct {
    logic [SCU_ID_WIDTH-1:0]        id;
    logic [L1D_LINE_ADDR_WIDTH-1:0] line;
    logic                           hit;
    logic                           dirty;
    logic [L1D_LINE_WIDTH-1:0]      data;
  } pipe_ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvh_l1d_snp_ctrl_if bus ();

  rvh_l1d_snp_ctrl #(.SNP_BUF_DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cache_scu_cc_snp_resp_t exp_q[$];
  pipe_ent_t              pipe_q[$];
  int total = 0;
  int bad   = 0;
  bit pipe_auto = 1'b1;
  int stray_req  = 0;
  int stray_done = 0;

  logic [L1D_LINE_WIDTH-1:0] d1;
  logic [L1D_LINE_WIDTH-1:0] d2;
  logic [L1D_LINE_WIDTH-1:0] d3;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Issue one snoop; push hand-computed response expectation when tracked
  task automatic send(input logic [SCU_ID_WIDTH-1:0] id, input snp_opcode_e op,
                      input logic [L1D_LINE_ADDR_WIDTH-1:0] line,
                      input logic hit, input logic dirty, input logic [L1D_LINE_WIDTH-1:0] data,
                      input logic pd, input logic dv, input logic sh, input bit track);
    int n;
    pipe_ent_t p;
    cache_scu_cc_snp_resp_t r;
    n = 0;
    while (!bus.snp_req_rdy_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      timeout("enq_wait");
      return;
    end
    bus.snp_req_vld_i         = 1'b1;
    bus.snp_req_i.id          = id;
    bus.snp_req_i.opcode      = op;
    bus.snp_req_i.line_addr   = line;
    p.id = id; p.line = line; p.hit = hit; p.dirty = dirty; p.data = data;
    pipe_q.push_back(p);
    if (track) begin
      r.id         = id;
      r.pass_dirty = pd;
      r.data_vld   = dv;
      r.is_shared  = sh;
      r.data       = dv ? data : '0;
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
    bus.snp_req_vld_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.snp_busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("idle_wait");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Pipeline model: grant immediately, answer one cycle after the grant
  initial begin
    pipe_ent_t p;
    bus.snp_pipe_resp_vld_i   = 1'b0;
    bus.snp_pipe_resp_hit_i   = 1'b0;
    bus.snp_pipe_resp_dirty_i = 1'b0;
    bus.snp_pipe_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        @(posedge clk); #1;
        bus.snp_pipe_resp_vld_i   = 1'b1;
        bus.snp_pipe_resp_hit_i   = 1'b1;
        bus.snp_pipe_resp_dirty_i = 1'b1;
        bus.snp_pipe_resp_data_i  = '1;
        @(posedge clk); #1;
        bus.snp_pipe_resp_vld_i   = 1'b0;
      end else if (pipe_auto && !rst && bus.snp_pipe_req_vld_o && bus.snp_pipe_req_rdy_i) begin
        if (pipe_q.size() == 0) begin
          timeout("pipe_req_unexpected");
        end else begin
          p = pipe_q.pop_front();
          chk("pipe_req_id", CW'(bus.snp_pipe_req_o.id), CW'(p.id));
          chk("pipe_req_line", CW'(bus.snp_pipe_req_o.line_addr), CW'(p.line));
          @(posedge clk); #1;
          bus.snp_pipe_resp_vld_i   = 1'b1;
          bus.snp_pipe_resp_hit_i   = p.hit;
          bus.snp_pipe_resp_dirty_i = p.dirty;
          bus.snp_pipe_resp_data_i  = p.data;
          @(posedge clk); #1;
          bus.snp_pipe_resp_vld_i   = 1'b0;
        end
      end
    end
  end

  // Response monitor: compares handshakes against the scoreboard, checks stability
  initial begin
    cache_scu_cc_snp_resp_t held;
    cache_scu_cc_snp_resp_t e;
    bit have_held;
    have_held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_held = 1'b0;
      end else if (bus.snp_resp_vld_o) begin
        if (have_held) chk("resp_stable", CW'(bus.snp_resp_o), CW'(held));
        if (bus.snp_resp_rdy_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: got id %0d expected none", bus.snp_resp_o.id);
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", CW'(bus.snp_resp_o.id), CW'(e.id));
            chk("resp_pass_dirty", CW'(bus.snp_resp_o.pass_dirty), CW'(e.pass_dirty));
            chk("resp_data_vld", CW'(bus.snp_resp_o.data_vld), CW'(e.data_vld));
            chk("resp_is_shared", CW'(bus.snp_resp_o.is_shared), CW'(e.is_shared));
            chk("resp_data", CW'(bus.snp_resp_o.data), CW'(e.data));
          end
          have_held = 1'b0;
        end else begin
          held      = bus.snp_resp_o;
          have_held = 1'b1;
        end
      end else begin
        if (have_held) chk("resp_withdrawn", CW'(bus.snp_resp_vld_o), CW'(1));
        have_held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    int  n;
    bit  seen;
    d1 = {16{32'hDEAD_BEEF}};
    d2 = {16{32'h0123_4567}};
    d3 = {16{32'hA5A5_5A5A}};
    rst                     = 1'b1;
    bus.snp_req_vld_i       = 1'b0;
    bus.snp_req_i           = '0;
    bus.snp_chk_conflict_i  = 1'b0;
    bus.snp_pipe_req_rdy_i  = 1'b1;
    bus.snp_resp_rdy_i      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", CW'(bus.snp_req_rdy_o), CW'(1));
    chk("rst_busy", CW'(bus.snp_busy_o), CW'(0));
    chk("rst_pipe_vld", CW'(bus.snp_pipe_req_vld_o), CW'(0));
    chk("rst_resp_vld", CW'(bus.snp_resp_vld_o), CW'(0));
    chk("rst_chk_line", CW'(bus.snp_chk_line_addr_o), CW'(0));
    chk("rst_resp_payload", CW'(bus.snp_resp_o), CW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // SnpShared, dirty hit, no stalls: 4-cycle response latency
    send(4'h1, SNP_SHARED, 34'h0_1234_5678, 1'b1, 1'b1, d1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("head_line_addr", CW'(bus.snp_chk_line_addr_o), CW'(34'h0_1234_5678));
    chk("busy_after_enq", CW'(bus.snp_busy_o), CW'(1));
    n = 0;
    while (!bus.snp_resp_vld_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_latency", CW'(n), CW'(4));
    wait_idle();

    // SnpUnique clean hit, SnpShared miss, SnpOnce clean hit, SnpUnique dirty hit
    send(4'h5, SNP_UNIQUE, 34'h0_0000_0100, 1'b1, 1'b0, d2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    send(4'h6, SNP_SHARED, 34'h0_0000_0200, 1'b0, 1'b0, d2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    send(4'h7, SNP_ONCE, 34'h0_0000_0300, 1'b1, 1'b0, d3, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle();
    send(4'h8, SNP_UNIQUE, 34'h0_0000_0400, 1'b1, 1'b1, d1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Held conflict: buffer fills, no lookup until the cycle after it drops
    bus.snp_chk_conflict_i = 1'b1;
    send(4'h9, SNP_SHARED, 34'h1_0000_0010, 1'b1, 1'b1, d2, 1'b1, 1'b1, 1'b1, 1'b1);
    send(4'hA, SNP_MAKE_INVALID, 34'h1_0000_0020, 1'b1, 1'b1, d3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_req_rdy", CW'(bus.snp_req_rdy_o), CW'(0));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.snp_pipe_req_vld_o) seen = 1'b1;
    end
    chk("conflict_no_issue", CW'(seen), CW'(0));
    @(posedge clk); #1;
    bus.snp_chk_conflict_i = 1'b0;
    @(negedge clk);
    chk("conflict_drop_cycle", CW'(bus.snp_pipe_req_vld_o), CW'(0));
    @(negedge clk);
    chk("conflict_issue_next", CW'(bus.snp_pipe_req_vld_o), CW'(1));
    wait_idle();

    // Back-to-back with the SCU stalling the first response for 3 cycles
    bus.snp_resp_rdy_i = 1'b0;
    send(4'hB, SNP_SHARED, 34'h2_0000_0001, 1'b1, 1'b1, d3, 1'b1, 1'b1, 1'b1, 1'b1);
    send(4'hC, SNP_ONCE, 34'h2_0000_0002, 1'b1, 1'b0, d1, 1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    while (!bus.snp_resp_vld_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("b2b_resp_wait");
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.snp_resp_rdy_i = 1'b1;
    @(negedge clk);
    chk("b2b_head_before_pop", CW'(bus.snp_chk_line_addr_o), CW'(34'h2_0000_0001));
    @(negedge clk);
    chk("b2b_check_line", CW'(bus.snp_chk_line_addr_o), CW'(34'h2_0000_0002));
    chk("b2b_check_no_issue", CW'(bus.snp_pipe_req_vld_o), CW'(0));
    @(negedge clk);
    chk("b2b_issue", CW'(bus.snp_pipe_req_vld_o), CW'(1));
    wait_idle();

    // Reset while the lookup is outstanding, then a stray lookup response
    pipe_auto = 1'b0;
    send(4'hD, SNP_SHARED, 34'h3_0000_0040, 1'b1, 1'b1, d1, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.snp_pipe_req_vld_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) timeout("wait_issue");
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_req_rdy", CW'(bus.snp_req_rdy_o), CW'(1));
    chk("midrst_busy", CW'(bus.snp_busy_o), CW'(0));
    chk("midrst_pipe_vld", CW'(bus.snp_pipe_req_vld_o), CW'(0));
    chk("midrst_resp_vld", CW'(bus.snp_resp_vld_o), CW'(0));
    chk("midrst_chk_line", CW'(bus.snp_chk_line_addr_o), CW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pipe_q.delete();
    stray_req++;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.snp_resp_vld_o || bus.snp_pipe_req_vld_o) seen = 1'b1;
    end
    chk("stray_no_resp", CW'(seen), CW'(0));
    chk("stray_busy", CW'(bus.snp_busy_o), CW'(0));
    pipe_auto = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset: SnpShared miss
    send(4'hE, SNP_SHARED, 34'h3_0000_0080, 1'b0, 1'b1, d2, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();

    chk("scoreboard_drained", CW'(exp_q.size()), CW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rvh_l1d_snp_ctrl
`default_nettype wire
